// File: rtl/bcd_digit_feeder.sv
// bcd_digit_feeder: sequential double-dabble converter that turns a binary value
// into eight 7-bit digit codes for the multiplexed seven-segment controller.
// Code format: bit6 = lit, bit5 = decimal point, bits4:0 = character (0x10 = dash).
// Optional build macro LEAD_ZERO_BLANK_EN blanks leading zero digits (d0 always lit).
module bcd_digit_feeder #(
   parameter int unsigned W = 27
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] bin,
   input  logic [7:0]   dp_mask,
   output logic         busy,
   output logic         done,
   output logic         ovf,
   output logic [6:0]   d7,
   output logic [6:0]   d6,
   output logic [6:0]   d5,
   output logic [6:0]   d4,
   output logic [6:0]   d3,
   output logic [6:0]   d2,
   output logic [6:0]   d1,
   output logic [6:0]   d0
);

   localparam int unsigned BCD_W     = 32;
   localparam int unsigned N_DIG     = 8;
   localparam int unsigned CNT_W     = $clog2(W);
   localparam logic [31:0] OVF_LIMIT = 32'd99_999_999;
   localparam logic [6:0]  DASH_CODE = 7'h50;
   localparam logic [6:0]  POINT_ONLY = 7'h20;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_UPD  = 2'd2
   } state_t;

   state_t             state;
   logic [W-1:0]       bin_sh;
   logic [BCD_W-1:0]   bcd;
   logic [BCD_W-1:0]   bcd_adj;
   logic [CNT_W-1:0]   cnt;
   logic [7:0]         dp_r;
   logic               ovf_cap;
   logic [6:0]         dig_q    [N_DIG];
   logic [6:0]         dig_next [N_DIG];

   // Add-3 correction on every BCD nibble that would reach 10 or more after the shift
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < int'(N_DIG); i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   // Digit codes presented at the update cycle, scanning from the most significant digit
   always_comb begin
      logic [3:0] nib;
`ifdef LEAD_ZERO_BLANK_EN
      logic       lead;
      lead = 1'b1;
`endif
      nib = 4'd0;
      for (int i = int'(N_DIG) - 1; i >= 0; i--) begin
         nib         = bcd[4*i +: 4];
         dig_next[i] = {1'b1, dp_r[i], 1'b0, nib};
`ifdef LEAD_ZERO_BLANK_EN
         if (lead && (nib == 4'd0) && (i != 0)) begin
            dig_next[i] = dp_r[i] ? POINT_ONLY : 7'h00;
         end else begin
            lead = 1'b0;
         end
`endif
         if (ovf_cap) begin
            dig_next[i] = DASH_CODE;
         end
      end
   end

   // Control FSM with conversion datapath and registered display outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         bin_sh  <= '0;
         bcd     <= '0;
         cnt     <= '0;
         dp_r    <= '0;
         ovf_cap <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ovf     <= 1'b0;
         for (int i = 0; i < int'(N_DIG); i++) begin
            dig_q[i] <= 7'h00;
         end
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  bin_sh  <= bin;
                  dp_r    <= dp_mask;
                  bcd     <= '0;
                  cnt     <= CNT_W'(W - 1);
                  ovf_cap <= (32'(bin) > OVF_LIMIT);
                  busy    <= 1'b1;
                  state   <= S_CONV;
               end
            end
            S_CONV: begin
               {bcd, bin_sh} <= {bcd_adj, bin_sh} << 1;
               cnt           <= cnt - CNT_W'(1);
               if (cnt == '0) begin
                  state <= S_UPD;
               end
            end
            S_UPD: begin
               for (int i = 0; i < int'(N_DIG); i++) begin
                  dig_q[i] <= dig_next[i];
               end
               ovf   <= ovf_cap;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign d7 = dig_q[7];
   assign d6 = dig_q[6];
   assign d5 = dig_q[5];
   assign d4 = dig_q[4];
   assign d3 = dig_q[3];
   assign d2 = dig_q[2];
   assign d1 = dig_q[1];
   assign d0 = dig_q[0];

endmodule
